// File: rtl/sar_pkg.sv
// Shared types and sizing helpers for the SAR ADC controller.
package sar_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SAMPLE = 2'd1,
    TRIAL  = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam int unsigned DEF_SETTLE_CYCLES = 1;
  // Per-bit trial window: DAC settle plus the two synchronizer stages.
  localparam int unsigned W = DEF_SETTLE_CYCLES + 2;

  // Bits needed to hold a down-counter starting at max_val (at least 1).
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer bringing the asynchronous comparator output into clk.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/sar_adc_ctrl.sv
// Successive-approximation controller: tracks via the S/H switch, then resolves
// one result bit per trial window, MSB first, using the synchronized comparator.
module sar_adc_ctrl
  import sar_pkg::*;
#(
  parameter int unsigned N_BITS        = 8,
  parameter int unsigned SAMPLE_CYCLES = 4,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              cmp_in,
  output logic              sh_ctrl,
  output logic [N_BITS-1:0] dac_code,
  output logic              busy,
  output logic              done,
  output logic [N_BITS-1:0] result
);

  localparam int unsigned TRIAL_CYCLES = SETTLE_CYCLES + 2;
  localparam int unsigned CNT_MAX =
    ((SAMPLE_CYCLES > TRIAL_CYCLES) ? SAMPLE_CYCLES : TRIAL_CYCLES) - 1;
  localparam int unsigned CW = cnt_width(CNT_MAX);
  localparam int unsigned IW = cnt_width(N_BITS - 1);

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [N_BITS-1:0] approx_q, approx_d;
  logic [N_BITS-1:0] result_d, dac_d;
  logic [N_BITS-1:0] bit_mask, approx_dec;
  logic              sh_d, busy_d, done_d;
  logic              cmp_sync;

  sync_2ff u_cmp_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (cmp_in),
    .q     (cmp_sync)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      approx_q <= '0;
      result   <= '0;
      dac_code <= '0;
      sh_ctrl  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      approx_q <= approx_d;
      result   <= result_d;
      dac_code <= dac_d;
      sh_ctrl  <= sh_d;
      busy     <= busy_d;
      done     <= done_d;
    end
  end

  // Next state and next values of every registered output.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    approx_d   = approx_q;
    result_d   = result;
    dac_d      = dac_code;
    sh_d       = sh_ctrl;
    busy_d     = busy;
    done_d     = 1'b0;
    bit_mask   = N_BITS'(1) << idx_q;
    approx_dec = cmp_sync ? (approx_q | bit_mask) : approx_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SAMPLE;
          cnt_d   = CW'(SAMPLE_CYCLES - 1);
          sh_d    = 1'b1;
          busy_d  = 1'b1;
          dac_d   = '0;
        end
      end
      SAMPLE: begin
        if (cnt_q == '0) begin
          state_d  = TRIAL;
          cnt_d    = CW'(TRIAL_CYCLES - 1);
          idx_d    = IW'(N_BITS - 1);
          approx_d = '0;
          sh_d     = 1'b0;
          dac_d    = N_BITS'(1) << (N_BITS - 1);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      TRIAL: begin
        if (cnt_q == '0) begin
          approx_d = approx_dec;
          if (idx_q == '0) begin
            state_d  = DONE;
            result_d = approx_dec;
            done_d   = 1'b1;
            dac_d    = '0;
          end else begin
            idx_d = idx_q - IW'(1);
            cnt_d = CW'(TRIAL_CYCLES - 1);
            dac_d = approx_dec | (bit_mask >> 1);
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort wins over everything outside IDLE and leaves result untouched.
    if (abort && (state_q != IDLE)) begin
      state_d  = IDLE;
      sh_d     = 1'b0;
      dac_d    = '0;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      result_d = result;
    end
  end

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Directed bench for sar_adc_ctrl: table of conversions plus hand-written
// sequences for back-to-back starts, async reset and abort.
module tb_sar_adc_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic       cmp_in;
  logic       sh_ctrl;
  logic [7:0] dac_code;
  logic       busy;
  logic       done;
  logic [7:0] result;

  // 0 = comparator model, 1 = tied high, 2 = tied low
  int         mode;
  logic [7:0] held;
  logic [7:0] last_res;
  int         checks;
  int         errors;

  typedef struct {
    int         mode;
    logic [7:0] held;
    logic [7:0] exp_res;
    bit         repulse;
    int         abort_at;
    bit         chk_dac;
  } vec_t;

  vec_t vecs [5];

  sar_adc_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .cmp_in   (cmp_in),
    .sh_ctrl  (sh_ctrl),
    .dac_code (dac_code),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Held voltage sits mid-code (held + 0.5 LSB), so held >= dac means input > DAC.
  assign cmp_in = (mode == 1) ? 1'b1 : (mode == 2) ? 1'b0 : (held >= dac_code);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One conversion: cycle k is the period after the (k-1)th edge following acceptance.
  task automatic convert(input vec_t v);
    int         done_cyc;
    int         done_cnt;
    int         exp_end;
    bit         busy_ok, sh_ok, dac_ok, hold_ok;
    logic [7:0] res_at_done;
    done_cyc = 0; done_cnt = 0;
    busy_ok = 1'b1; sh_ok = 1'b1; dac_ok = 1'b1; hold_ok = 1'b1;
    res_at_done = 8'h00;
    exp_end = (v.abort_at != 0) ? v.abort_at : 29;
    mode = v.mode;
    held = v.held;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int cyc = 1; cyc <= 34; cyc++) begin
      if (cyc > 1) @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      if (busy !== (cyc <= exp_end)) busy_ok = 1'b0;
      if (sh_ctrl !== (cyc <= 4 && cyc <= exp_end)) sh_ok = 1'b0;
      if (done === 1'b1) begin
        done_cnt++;
        done_cyc    = cyc;
        res_at_done = result;
      end
      if ((cyc < 29 || v.abort_at != 0) && result !== last_res) hold_ok = 1'b0;
      if ((cyc <= 4 || cyc > exp_end) && dac_code !== 8'h00) dac_ok = 1'b0;
      if (v.chk_dac && cyc >= 5 && cyc <= 28 && dac_code !== (8'h80 >> ((cyc - 5) / 3)))
        dac_ok = 1'b0;
      if (v.repulse && (cyc == 2 || cyc == 10)) start = 1'b1;
      if (cyc == v.abort_at) abort = 1'b1;
    end
    start = 1'b0;
    abort = 1'b0;
    if (v.abort_at != 0) begin
      chk("abort_no_done", done_cnt, 0);
      chk("abort_result_kept", result, last_res);
    end else begin
      chk("done_count", done_cnt, 1);
      chk("done_latency", done_cyc, 29);
      chk("result_at_done", res_at_done, v.exp_res);
      chk("result_held", result, v.exp_res);
      last_res = v.exp_res;
    end
    chk("busy_window", busy_ok, 1);
    chk("sh_ctrl_window", sh_ok, 1);
    chk("dac_sequence", dac_ok, 1);
    chk("result_stable", hold_ok, 1);
  endtask

  initial begin
    int done_list [$];
    int sh_cnt;
    int wait_cnt;
    vec_t v;
    checks = 0; errors = 0;
    mode = 0; held = 8'h00; last_res = 8'h00;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;

    vecs[0] = '{mode: 0, held: 8'hA5, exp_res: 8'hA5, repulse: 1'b0, abort_at: 0, chk_dac: 1'b0};
    vecs[1] = '{mode: 1, held: 8'h00, exp_res: 8'hFF, repulse: 1'b0, abort_at: 0, chk_dac: 1'b0};
    vecs[2] = '{mode: 2, held: 8'h00, exp_res: 8'h00, repulse: 1'b0, abort_at: 0, chk_dac: 1'b1};
    vecs[3] = '{mode: 0, held: 8'h01, exp_res: 8'h01, repulse: 1'b0, abort_at: 0, chk_dac: 1'b0};
    vecs[4] = '{mode: 0, held: 8'h80, exp_res: 8'h80, repulse: 1'b1, abort_at: 0, chk_dac: 1'b0};

    repeat (3) @(negedge clk);
    chk("reset_sh_ctrl", sh_ctrl, 0);
    chk("reset_dac_code", dac_code, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_result", result, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 5; i++) convert(vecs[i]);

    // start held high: back-to-back conversions every 30 cycles
    mode = 0; held = 8'h5A; sh_cnt = 0;
    @(negedge clk); start = 1'b1;
    for (int cyc = 1; cyc <= 95; cyc++) begin
      @(negedge clk);
      if (done === 1'b1) done_list.push_back(cyc);
      if (sh_ctrl === 1'b1) sh_cnt++;
    end
    start = 1'b0;
    chk("b2b_done_count", done_list.size(), 3);
    if (done_list.size() == 3) begin
      chk("b2b_first_done", done_list[0], 29);
      chk("b2b_period_1", done_list[1] - done_list[0], 30);
      chk("b2b_period_2", done_list[2] - done_list[1], 30);
    end
    chk("b2b_sh_cycles", sh_cnt, 16);
    chk("b2b_result", result, 8'h5A);
    wait_cnt = 0;
    while (busy === 1'b1 && wait_cnt < 40) begin
      @(negedge clk);
      wait_cnt++;
    end
    chk("b2b_drain_timeout", busy, 0);
    last_res = result;

    // async reset between edges in the middle of a trial
    mode = 0; held = 8'hC3;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (11) @(negedge clk);
    chk("pre_reset_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_sh_ctrl", sh_ctrl, 0);
    chk("async_rst_dac_code", dac_code, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_done", done, 0);
    chk("async_rst_result", result, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    last_res = 8'h00;
    v = '{mode: 0, held: 8'h3C, exp_res: 8'h3C, repulse: 1'b0, abort_at: 0, chk_dac: 1'b0};
    convert(v);

    // abort at cycle 10 keeps the prior result
    v = '{mode: 0, held: 8'h77, exp_res: 8'h3C, repulse: 1'b0, abort_at: 10, chk_dac: 1'b0};
    convert(v);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
